// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit: state codes,
// opcodes and the mux/ALU encodings the datapath decodes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXEC_R  = 3'd2,
        ST_WB_R    = 3'd3,
        ST_BRANCH  = 3'd4,
        ST_JUMP    = 3'd5,
        ST_ILLEGAL = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic       ALU_A_PC  = 1'b0;
    localparam logic       ALU_A_REG = 1'b1;

    localparam logic [1:0] ALU_B_REG  = 2'b00;
    localparam logic [1:0] ALU_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_B_IMM  = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    typedef struct packed {
        logic       im_req;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
    } ctrl_t;

    // Opcodes outside the supported subset all funnel into ST_ILLEGAL.
    function automatic state_t decode_opcode(input logic [5:0] opcode);
        state_t nxt;
        case (opcode)
            OP_RTYPE: nxt = ST_EXEC_R;
            OP_BEQ:   nxt = ST_BRANCH;
            OP_J:     nxt = ST_JUMP;
            default:  nxt = ST_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decode. Only FETCH looks at im_ready and
// only BRANCH looks at zero; reset masks every write enable and the fetch request.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   reset,
    input  logic   im_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.pc_src    = PC_SRC_SEQ;
            ctrl.alu_src_a = ALU_A_PC;
            ctrl.alu_src_b = ALU_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
        end else begin
            case (state)
                ST_FETCH: begin
                    ctrl.im_req    = 1'b1;
                    ctrl.alu_src_a = ALU_A_PC;
                    ctrl.alu_src_b = ALU_B_FOUR;
                    ctrl.alu_op    = ALU_OP_ADD;
                    ctrl.pc_src    = PC_SRC_SEQ;
                    ctrl.ir_write  = im_ready;
                    ctrl.pc_en     = im_ready;
                end
                // ALU precomputes the branch target into ALUOut while the opcode settles.
                ST_DECODE: begin
                    ctrl.alu_src_a = ALU_A_PC;
                    ctrl.alu_src_b = ALU_B_IMM;
                    ctrl.alu_op    = ALU_OP_ADD;
                end
                ST_EXEC_R: begin
                    ctrl.alu_src_a = ALU_A_REG;
                    ctrl.alu_src_b = ALU_B_REG;
                    ctrl.alu_op    = ALU_OP_FUNCT;
                end
                ST_WB_R: begin
                    ctrl.reg_write = 1'b1;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a = ALU_A_REG;
                    ctrl.alu_src_b = ALU_B_REG;
                    ctrl.alu_op    = ALU_OP_SUB;
                    ctrl.pc_src    = PC_SRC_BRANCH;
                    ctrl.pc_en     = zero;
                end
                ST_JUMP: begin
                    ctrl.pc_src = PC_SRC_JUMP;
                    ctrl.pc_en  = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: owns the state register, sticky illegal flag and
// retired-instruction counter; control outputs come from mc_ctrl_decode.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             im_ready,
    output logic             im_req,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t cur_state;
    ctrl_t  ctrl;

    // Instructions retire on the edge that leaves their last state; illegal
    // latches on the decode edge so it is already high while in ST_ILLEGAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_FETCH;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            case (cur_state)
                ST_FETCH: begin
                    if (im_ready) begin
                        cur_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    cur_state <= decode_opcode(opcode);
                    if (decode_opcode(opcode) == ST_ILLEGAL) begin
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC_R: begin
                    cur_state <= ST_WB_R;
                end
                ST_WB_R, ST_BRANCH, ST_JUMP: begin
                    cur_state <= ST_FETCH;
                    retired   <= retired + CNT_W'(1);
                end
                ST_ILLEGAL: begin
                    cur_state <= ST_FETCH;
                end
                default: begin
                    cur_state <= ST_FETCH;
                end
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .state    (cur_state),
        .reset    (reset),
        .im_ready (im_ready),
        .zero     (zero),
        .ctrl     (ctrl)
    );

    assign im_req    = ctrl.im_req;
    assign ir_write  = ctrl.ir_write;
    assign pc_en     = ctrl.pc_en;
    assign pc_src    = ctrl.pc_src;
    assign alu_src_a = ctrl.alu_src_a;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign reg_write = ctrl.reg_write;
    assign state     = cur_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes the hand-derived output
// word for each cycle, a negedge monitor pops and compares it.
module tb_mc_control_fsm;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             zero;
    logic             im_ready;
    logic             im_req;
    logic             ir_write;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             illegal;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [2:0]       st;
        logic             req;
        logic             irw;
        logic             pce;
        logic [1:0]       pcs;
        logic             asa;
        logic [1:0]       asb;
        logic [1:0]       aop;
        logic             rw;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    fails  = 0;

    logic [CNT_W-1:0] exp_ret;
    logic             exp_ill;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .im_ready  (im_ready),
        .im_req    (im_req),
        .ir_write  (ir_write),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .illegal   (illegal),
        .state     (state),
        .retired   (retired)
    );

    function automatic obs_t mk(input logic [2:0] st, input logic req, input logic irw,
                                input logic pce, input logic [1:0] pcs, input logic asa,
                                input logic [1:0] asb, input logic [1:0] aop, input logic rw,
                                input logic ill, input logic [CNT_W-1:0] ret);
        obs_t o;
        o.st = st; o.req = req; o.irw = irw; o.pce = pce; o.pcs = pcs;
        o.asa = asa; o.asb = asb; o.aop = aop; o.rw = rw; o.ill = ill; o.ret = ret;
        return o;
    endfunction

    task automatic check_output(input string tag, input obs_t e);
        obs_t a;
        a = mk(state, im_req, ir_write, pc_en, pc_src, alu_src_a, alu_src_b, alu_op,
               reg_write, illegal, retired);
        checks++;
        if (a !== e) begin
            fails++;
            $display("[TB] FAIL %s: got st=%0d req=%b irw=%b pce=%b pcs=%b asa=%b asb=%b aop=%b rw=%b ill=%b ret=%0d, expected st=%0d req=%b irw=%b pce=%b pcs=%b asa=%b asb=%b aop=%b rw=%b ill=%b ret=%0d",
                     tag, a.st, a.req, a.irw, a.pce, a.pcs, a.asa, a.asb, a.aop, a.rw, a.ill, a.ret,
                     e.st, e.req, e.irw, e.pce, e.pcs, e.asa, e.asb, e.aop, e.rw, e.ill, e.ret);
        end
    endtask

    always @(negedge clk) begin
        obs_t  e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_output(t, e);
        end
    end

    task automatic apply_stimulus(input logic rst, input logic [5:0] op, input logic z,
                                  input logic rdy, input obs_t e, input string tag);
        reset    = rst;
        opcode   = op;
        zero     = z;
        im_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_cycle(input logic [5:0] op, input logic rdy, input string tag);
        apply_stimulus(0, op, 1'b1, rdy,
                       mk(3'd0, 1, rdy, rdy, 2'b00, 0, 2'b01, 2'b00, 0, exp_ill, exp_ret), tag);
    endtask

    task automatic decode_cycle(input logic [5:0] op, input string tag);
        apply_stimulus(0, op, 1'b1, 1'b1,
                       mk(3'd1, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, exp_ill, exp_ret), tag);
    endtask

    task automatic run_rtype(input string tag);
        fetch_cycle(6'h00, 1'b1, {tag, " fetch"});
        decode_cycle(6'h00, {tag, " decode"});
        apply_stimulus(0, 6'h00, 1'b1, 1'b1,
                       mk(3'd2, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, exp_ill, exp_ret), {tag, " exec"});
        apply_stimulus(0, 6'h00, 1'b1, 1'b1,
                       mk(3'd3, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, exp_ill, exp_ret), {tag, " wb"});
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_beq(input logic z, input string tag);
        fetch_cycle(6'h04, 1'b1, {tag, " fetch"});
        decode_cycle(6'h04, {tag, " decode"});
        apply_stimulus(0, 6'h04, z, 1'b1,
                       mk(3'd4, 0, 0, z, 2'b01, 1, 2'b00, 2'b01, 0, exp_ill, exp_ret), {tag, " branch"});
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_jump(input string tag);
        fetch_cycle(6'h02, 1'b1, {tag, " fetch"});
        decode_cycle(6'h02, {tag, " decode"});
        apply_stimulus(0, 6'h02, 1'b1, 1'b1,
                       mk(3'd5, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, exp_ill, exp_ret), {tag, " jump"});
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_illegal(input logic [5:0] op, input string tag);
        fetch_cycle(op, 1'b1, {tag, " fetch"});
        decode_cycle(op, {tag, " decode"});
        exp_ill = 1'b1;
        apply_stimulus(0, op, 1'b1, 1'b1,
                       mk(3'd6, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, exp_ill, exp_ret), {tag, " illegal"});
    endtask

    initial begin
        reset    = 1'b1;
        opcode   = 6'h00;
        zero     = 1'b0;
        im_ready = 1'b1;
        exp_ret  = '0;
        exp_ill  = 1'b0;
        @(posedge clk);
        #1;
        // Second reset cycle: state already FETCH, enables and im_req masked.
        apply_stimulus(1, 6'h00, 1'b1, 1'b1,
                       mk(3'd0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 1'b0, '0), "reset hold");

        run_rtype("rtype");
        run_beq(1'b1, "beq taken");
        run_beq(1'b0, "beq not taken");
        run_jump("jump");
        run_illegal(6'h23, "op 0x23");

        for (int i = 0; i < 5; i++) begin
            fetch_cycle(6'h00, 1'b0, $sformatf("stall %0d", i));
        end
        run_rtype("after stall");

        fetch_cycle(6'h00, 1'b1, "abort fetch");
        decode_cycle(6'h00, "abort decode");
        apply_stimulus(1, 6'h00, 1'b1, 1'b1,
                       mk(3'd2, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, exp_ill, exp_ret), "abort reset in exec");
        exp_ret = '0;
        exp_ill = 1'b0;
        fetch_cycle(6'h00, 1'b0, "abort resumes fetch");

        while (exp_ret != {CNT_W{1'b1}}) begin
            run_jump("fill");
        end
        run_rtype("wrap rtype");
        fetch_cycle(6'h00, 1'b0, "wrap to zero");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control unit for the MIPS-subset datapath: register file/ALU, instruction memory, and the PC-select mux.
- Sequences each instruction through fetch, decode, execute and writeback.
- Drives PC/IR write enables, mux selects and ALU op; consumes the opcode and the ALU zero flag from the datapath.
- Sits directly upstream of the datapath, replacing hand-sequenced stimulus with clocked control.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
opcode  input  6  instruction bits [31:26], valid from DECODE onward (IR already loaded)
zero  input  1  ALU zero flag from the datapath
im_ready  input  1  instruction memory has data valid this cycle
im_req  output  1  fetch request to instruction memory
ir_write  output  1  load instruction register
pc_en  output  1  PC register write enable
pc_src  output  2  00 = PC+4 (ALU result), 01 = branch target (ALUOut), 10 = jump address
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = register B, 01 = constant 4, 11 = sign-extended imm<<2
alu_op  output  2  00 = add, 01 = subtract, 10 = funct-decoded
reg_write  output  1  register file write enable (destination = rd)
illegal  output  1  sticky: an unsupported opcode was decoded
state  output  3  current state, for debug
retired  output  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset: on the clk edge with reset=1, state=FETCH, illegal=0, retired=0.
  - While reset=1, ir_write, pc_en, reg_write and im_req are forced 0.
  - All other outputs take FETCH decode values: pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=00.
- Moore outputs are decoded from state. The only inputs used are im_ready (in FETCH) and zero (in BRANCH). Unlisted outputs are 0.
- State encoding: FETCH=0, DECODE=1, EXEC_R=2, WB_R=3, BRANCH=4, JUMP=5, ILLEGAL=6. Code 7 returns to FETCH with no side effects.
- FETCH:
  - im_req=1, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If im_ready=1: ir_write=1, pc_en=1, pc_src=00; next state DECODE.
  - If im_ready=0: stay in FETCH; ir_write=pc_en=0. Stall length is unbounded.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target computed into ALUOut). Next state by opcode:
  - 6'h00 -> EXEC_R
  - 6'h04 -> BRANCH
  - 6'h02 -> JUMP
  - any other -> ILLEGAL
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next state WB_R.
- WB_R: reg_write=1; next state FETCH; retired+1.
- BRANCH (BEQ): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; next state FETCH; retired+1 whether taken or not.
- JUMP: pc_src=10, pc_en=1; next state FETCH; retired+1.
- ILLEGAL: illegal set to 1 (sticky until reset); no writes; next state FETCH; retired unchanged.
- Cycle counts with im_ready held high:
  - R-type: 4 cycles
  - BEQ: 3 cycles
  - J: 3 cycles
- retired wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-instruction: the state is abandoned with no further writes; the next cycle after reset is FETCH.
- Reset has priority over every transition and counter update in the same cycle.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - the state enum/localparams
  - opcode constants OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_J=6'h02
  - encodings for pc_src, alu_src_b and alu_op, shared with the datapath mux and ALU control
- Optional sub-module mc_ctrl_decode: purely combinational state -> control-word decode, keeping the FSM register and counter in the top.

Test Plan:
- Reset held 2 cycles, then released with im_ready=1 -> state=0, im_req=1, illegal=0, retired=0. Write enables are 0 during reset.
- R-type, opcode 0x00, im_ready=1 -> states 0,1,2,3,0.
  - ir_write/pc_en pulse in cycle 1; reg_write pulses in cycle 4 only; retired=1.
- BEQ, opcode 0x04:
  - zero=1 -> pc_en=1 with pc_src=01 in BRANCH.
  - Repeat with zero=0 -> pc_en=0.
  - Both cases take 3 cycles and increment retired.
- J (opcode 0x02) then illegal opcode 0x23:
  - JUMP asserts pc_en=1 with pc_src=10.
  - The illegal opcode enters state 6, illegal latches 1, retired is unchanged, FSM returns to FETCH; illegal stays 1 until reset.
- im_ready low 5 cycles in FETCH -> state stays 0, im_req=1, ir_write=pc_en=0 throughout; advances the cycle im_ready rises.
- Reset asserted in EXEC_R -> reg_write never pulses, next state 0. Separately, preload retired=0xFFFF via 65535 R-types, run one more -> retired=0.
